// File: rtl/cpu16_pkg.sv
// Shared types and constants for the 16-bit CPU operand-entry path.
package cpu16_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int          NUM_DIGITS = 5;
  localparam int          ACC_W      = 18;
  localparam logic [16:0] POS_LIMIT  = 17'd32767;
  localparam logic [16:0] NEG_LIMIT  = 17'd32768;

  // A BCD digit is only meaningful in the range 0..9.
  function automatic logic is_bad_digit(input logic [3:0] digit);
    return digit > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_bin16_if.sv
// Operand-entry bus: start/done handshake, sign + five BCD digits in,
// signed 16-bit result and status flags out.
interface bcd_to_bin16_if;

  logic        start;
  logic        negative;
  logic [3:0]  bcd_digit0;
  logic [3:0]  bcd_digit1;
  logic [3:0]  bcd_digit2;
  logic [3:0]  bcd_digit3;
  logic [3:0]  bcd_digit4;
  logic        ready;
  logic        done;
  logic [15:0] result;
  logic        overflow;
  logic        invalid;

  modport master (
    output start, negative,
    output bcd_digit0, bcd_digit1, bcd_digit2, bcd_digit3, bcd_digit4,
    input  ready, done, result, overflow, invalid
  );

  modport slave (
    input  start, negative,
    input  bcd_digit0, bcd_digit1, bcd_digit2, bcd_digit3, bcd_digit4,
    output ready, done, result, overflow, invalid
  );

endinterface

// File: rtl/bcd_mac10.sv
// One Horner step: acc_next = acc*10 + digit, with the multiply done as
// (acc<<3)+(acc<<1). The accumulator is wide enough for five digits of 15.
module bcd_mac10
  import cpu16_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc_next
);

  assign acc_next = (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};

endmodule

// File: rtl/bcd_to_bin16.sv
// Sign + five BCD digits to signed 16-bit two's complement, one digit per
// clock, most-significant digit first.
// Optional macro BCD_DIGIT_CHECK_EN: when defined, digits above 9 raise
// 'invalid' and force a zero result; otherwise they accumulate at face value.
module bcd_to_bin16
  import cpu16_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  bcd_to_bin16_if.slave  bus
);

  state_t            state;
  state_t            state_next;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_step;
  logic [2:0]        count;
  logic              neg_held;
  logic [3:0]        held [NUM_DIGITS];
  logic [3:0]        cur_digit;
  logic              capture;
  logic              bad;
  logic [ACC_W-1:0]  limit;
  logic [15:0]       wrapped;
  logic [15:0]       fin_result;
  logic              fin_overflow;
  logic              done_q;
  logic [15:0]       result_q;
  logic              overflow_q;

  assign capture   = (state == IDLE) && bus.start;
  assign cur_digit = held[count];

  bcd_mac10 u_mac (
    .acc      (acc),
    .digit    (cur_digit),
    .acc_next (acc_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches.
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start) state_next = CONV;
      CONV:    if (count == 3'd0) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Digit holding registers, loaded on the accepted start.
  always_ff @(posedge clk) begin
    // NOTE: these have no reset; they are always written on capture before
    // anything reads them, so a reset would only add fan-out.
    if (capture) begin
      held[0] <= bus.bcd_digit0;
      held[1] <= bus.bcd_digit1;
      held[2] <= bus.bcd_digit2;
      held[3] <= bus.bcd_digit3;
      held[4] <= bus.bcd_digit4;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic invalid_q;

  // Any held digit outside 0..9 invalidates the conversion.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) bad = bad | is_bad_digit(held[i]);
  end

  // Sticky invalid flag, refreshed only when a result is published.
  always_ff @(posedge clk) begin
    if (reset)                 invalid_q <= 1'b0;
    else if (state == FINISH)  invalid_q <= bad;
  end

  assign bus.invalid = invalid_q;
`else
  assign bad         = 1'b0;
  assign bus.invalid = 1'b0;
`endif

  assign limit   = neg_held ? {{(ACC_W-17){1'b0}}, NEG_LIMIT}
                            : {{(ACC_W-17){1'b0}}, POS_LIMIT};
  // Low 16 bits of -acc only depend on the low 16 bits of acc.
  assign wrapped = neg_held ? (~acc[15:0] + 16'd1) : acc[15:0];

  // Range check and result selection for the FINISH cycle.
  always_comb begin
    fin_result   = 16'h0000;
    fin_overflow = 1'b0;
    if (!bad) begin
      if (acc > limit) begin
        fin_overflow = 1'b1;
        if (SATURATE) fin_result = neg_held ? 16'h8000 : 16'h7FFF;
        else          fin_result = wrapped;
      end else begin
        fin_result = wrapped;
      end
    end
  end

  // Accumulator, digit counter and published outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      count      <= 3'd0;
      neg_held   <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= 16'h0000;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            neg_held <= bus.negative;
            acc      <= '0;
            count    <= 3'(NUM_DIGITS - 1);
          end
        end
        CONV: begin
          acc   <= acc_step;
          count <= count - 3'd1;
        end
        FINISH: begin
          result_q   <= fin_result;
          overflow_q <= fin_overflow;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ready    = (state == IDLE);
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bcd_to_bin16.sv
// Directed bench for bcd_to_bin16: one saturating and one wrapping instance
// driven with identical stimulus.
module tb_bcd_to_bin16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  bcd_to_bin16_if if_sat ();
  bcd_to_bin16_if if_wrap ();

  bcd_to_bin16 #(.SATURATE(1'b1)) dut_sat  (.clk(clk), .reset(reset), .bus(if_sat));
  bcd_to_bin16 #(.SATURATE(1'b0)) dut_wrap (.clk(clk), .reset(reset), .bus(if_wrap));

  always #5 clk = ~clk;

  task automatic set_inputs(input logic st, input logic neg,
                            input logic [3:0] d4, input logic [3:0] d3,
                            input logic [3:0] d2, input logic [3:0] d1,
                            input logic [3:0] d0);
    if_sat.start       = st;  if_wrap.start      = st;
    if_sat.negative    = neg; if_wrap.negative   = neg;
    if_sat.bcd_digit4  = d4;  if_wrap.bcd_digit4 = d4;
    if_sat.bcd_digit3  = d3;  if_wrap.bcd_digit3 = d3;
    if_sat.bcd_digit2  = d2;  if_wrap.bcd_digit2 = d2;
    if_sat.bcd_digit1  = d1;  if_wrap.bcd_digit1 = d1;
    if_sat.bcd_digit0  = d0;  if_wrap.bcd_digit0 = d0;
  endtask

  // One start pulse, then wait (bounded) for done; lat = cycles from the
  // start edge to the edge that raises done, or -1 on timeout.
  task automatic do_conv(input logic neg, input logic [3:0] d4, input logic [3:0] d3,
                         input logic [3:0] d2, input logic [3:0] d1,
                         input logic [3:0] d0, output int lat);
    @(negedge clk);
    set_inputs(1'b1, neg, d4, d3, d2, d1, d0);
    @(posedge clk); #1;
    if_sat.start = 1'b0; if_wrap.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (if_sat.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_inputs(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (if_sat.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", if_sat.ready); end
    n_checks++; if (if_sat.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", if_sat.done); end
    n_checks++; if (if_sat.result !== 16'h0000) begin n_fail++; $display("FAIL reset_result: got %h want 0000", if_sat.result); end
    n_checks++; if (if_sat.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", if_sat.overflow); end
    n_checks++; if (if_sat.invalid !== 1'b0) begin n_fail++; $display("FAIL reset_invalid: got %b want 0", if_sat.invalid); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_positive();
    int lat;
    do_conv(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, lat);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL pos_latency: got %0d want 6", lat); end
    n_checks++; if (if_sat.result !== 16'h3039) begin n_fail++; $display("FAIL pos_result: got %h want 3039", if_sat.result); end
    n_checks++; if (if_wrap.result !== 16'h3039) begin n_fail++; $display("FAIL pos_result_wrap: got %h want 3039", if_wrap.result); end
    n_checks++; if (if_sat.overflow !== 1'b0) begin n_fail++; $display("FAIL pos_overflow: got %b want 0", if_sat.overflow); end
    n_checks++; if (if_sat.invalid !== 1'b0) begin n_fail++; $display("FAIL pos_invalid: got %b want 0", if_sat.invalid); end
    n_checks++; if (if_sat.ready !== 1'b1) begin n_fail++; $display("FAIL pos_ready: got %b want 1", if_sat.ready); end
    @(posedge clk); #1;
    n_checks++; if (if_sat.done !== 1'b0) begin n_fail++; $display("FAIL pos_done_pulse: got %b want 0", if_sat.done); end
    n_checks++; if (if_sat.result !== 16'h3039) begin n_fail++; $display("FAIL pos_result_hold: got %h want 3039", if_sat.result); end
  endtask

  task automatic test_negative_limits();
    int lat;
    do_conv(1'b1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd8, lat);
    n_checks++; if (if_sat.result !== 16'h8000) begin n_fail++; $display("FAIL neg_min_result: got %h want 8000", if_sat.result); end
    n_checks++; if (if_sat.overflow !== 1'b0) begin n_fail++; $display("FAIL neg_min_overflow: got %b want 0", if_sat.overflow); end
    n_checks++; if (if_wrap.result !== 16'h8000) begin n_fail++; $display("FAIL neg_min_result_wrap: got %h want 8000", if_wrap.result); end
    do_conv(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, lat);
    n_checks++; if (if_sat.result !== 16'hFFFF) begin n_fail++; $display("FAIL neg_one_result: got %h want ffff", if_sat.result); end
    do_conv(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, lat);
    n_checks++; if (if_sat.result !== 16'h0000) begin n_fail++; $display("FAIL neg_zero_result: got %h want 0000", if_sat.result); end
    n_checks++; if (if_sat.overflow !== 1'b0) begin n_fail++; $display("FAIL neg_zero_overflow: got %b want 0", if_sat.overflow); end
  endtask

  task automatic test_overflow();
    int lat;
    do_conv(1'b0, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, lat);
    n_checks++; if (if_sat.result !== 16'h7FFF) begin n_fail++; $display("FAIL ovf_pos_sat: got %h want 7fff", if_sat.result); end
    n_checks++; if (if_sat.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pos_sat_flag: got %b want 1", if_sat.overflow); end
    n_checks++; if (if_wrap.result !== 16'h9C40) begin n_fail++; $display("FAIL ovf_pos_wrap: got %h want 9c40", if_wrap.result); end
    n_checks++; if (if_wrap.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pos_wrap_flag: got %b want 1", if_wrap.overflow); end
    do_conv(1'b1, 4'd3, 4'd2, 4'd7, 4'd6, 4'd9, lat);
    n_checks++; if (if_sat.result !== 16'h8000) begin n_fail++; $display("FAIL ovf_neg_sat: got %h want 8000", if_sat.result); end
    n_checks++; if (if_sat.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_neg_sat_flag: got %b want 1", if_sat.overflow); end
    n_checks++; if (if_wrap.result !== 16'h7FFF) begin n_fail++; $display("FAIL ovf_neg_wrap: got %h want 7fff", if_wrap.result); end
    // +99999 is the largest legal entry.
    do_conv(1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, lat);
    n_checks++; if (if_wrap.result !== 16'h869F) begin n_fail++; $display("FAIL ovf_max_wrap: got %h want 869f", if_wrap.result); end
    // +32767 is the largest value that does not overflow.
    do_conv(1'b0, 4'd3, 4'd2, 4'd7, 4'd6, 4'd7, lat);
    n_checks++; if (if_sat.overflow !== 1'b0) begin n_fail++; $display("FAIL pos_max_flag: got %b want 0", if_sat.overflow); end
    n_checks++; if (if_sat.result !== 16'h7FFF) begin n_fail++; $display("FAIL pos_max_result: got %h want 7fff", if_sat.result); end
  endtask

  task automatic test_invalid();
    int lat;
    do_conv(1'b0, 4'd0, 4'd0, 4'hA, 4'd0, 4'd0, lat);
`ifdef BCD_DIGIT_CHECK_EN
    n_checks++; if (if_sat.invalid !== 1'b1) begin n_fail++; $display("FAIL inv_flag: got %b want 1", if_sat.invalid); end
    n_checks++; if (if_sat.result !== 16'h0000) begin n_fail++; $display("FAIL inv_result: got %h want 0000", if_sat.result); end
`else
    n_checks++; if (if_sat.invalid !== 1'b0) begin n_fail++; $display("FAIL inv_flag: got %b want 0", if_sat.invalid); end
    n_checks++; if (if_sat.result !== 16'h03E8) begin n_fail++; $display("FAIL inv_result: got %h want 03e8", if_sat.result); end
`endif
    n_checks++; if (if_sat.overflow !== 1'b0) begin n_fail++; $display("FAIL inv_overflow: got %b want 0", if_sat.overflow); end
  endtask

  task automatic test_back_to_back();
    int hits [$];
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7);
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (if_sat.done) hits.push_back(c);
    end
    if_sat.start = 1'b0; if_wrap.start = 1'b0;
    n_checks++; if (hits.size() !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", hits.size()); end
    if (hits.size() >= 2) begin
      n_checks++; if (hits[1] - hits[0] !== 7) begin n_fail++; $display("FAIL b2b_period: got %0d want 7", hits[1] - hits[0]); end
    end
    n_checks++; if (if_sat.result !== 16'h0007) begin n_fail++; $display("FAIL b2b_result: got %h want 0007", if_sat.result); end
    // Let the conversion started on the last done cycle drain.
    for (int c = 0; c < 20 && !if_sat.ready; c++) begin @(posedge clk); #1; end
    n_checks++; if (if_sat.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: got ready %b want 1", if_sat.ready); end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3);
    @(posedge clk); #1;
    if_sat.start = 1'b0; if_wrap.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Mid-conversion: new digits, sign and a start pulse must all be ignored.
    set_inputs(1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
    @(posedge clk); #1;
    if_sat.start = 1'b0; if_wrap.start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (if_sat.done) dones++;
      @(posedge clk); #1;
    end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL ignore_dones: got %0d want 1", dones); end
    n_checks++; if (if_sat.result !== 16'h007B) begin n_fail++; $display("FAIL ignore_result: got %h want 007b", if_sat.result); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    int lat;
    @(negedge clk);
    set_inputs(1'b1, 1'b0, 4'd0, 4'd0, 4'd4, 4'd5, 4'd6);
    @(posedge clk); #1;
    if_sat.start = 1'b0; if_wrap.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++; if (if_sat.ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", if_sat.ready); end
    n_checks++; if (if_sat.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", if_sat.done); end
    n_checks++; if (if_sat.result !== 16'h0000) begin n_fail++; $display("FAIL rstmid_result: got %h want 0000", if_sat.result); end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (if_sat.done) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", dones); end
    do_conv(1'b0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2, lat);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 6", lat); end
    n_checks++; if (if_sat.result !== 16'h002A) begin n_fail++; $display("FAIL rstmid_result2: got %h want 002a", if_sat.result); end
  endtask

  initial begin
    test_reset();
    test_positive();
    test_negative_limits();
    test_overflow();
    test_invalid();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin16.md
Name: bcd_to_bin16

Overview:
- Reverse path of the display chain: takes a sign flag plus five BCD digits from operand entry (switch/keypad front end) and produces a signed 16-bit two's-complement value for the CPU.
- Conversion is iterative Horner accumulation (acc = acc*10 + digit), one digit per clock, most-significant digit first.
- Start/done handshake; result stays registered until the next conversion.
- Flags out-of-range magnitudes and non-decimal digits.

Parameters:
- SATURATE, 1, 1 = clamp out-of-range results to 0x7FFF / 0x8000; 0 = keep the low 16 bits of the signed value (wrap).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request conversion; sampled only while ready=1
- negative  in  1  sign of entered value (1 = negative)
- bcd_digit0  in  4  units digit
- bcd_digit1  in  4  tens digit
- bcd_digit2  in  4  hundreds digit
- bcd_digit3  in  4  thousands digit
- bcd_digit4  in  4  ten-thousands digit
- ready  out  1  idle, able to accept start
- done  out  1  one-cycle pulse: result and flags updated
- result  out  16  signed two's-complement value
- overflow  out  1  magnitude out of 16-bit signed range (sticky until next done)
- invalid  out  1  some digit > 9 (sticky until next done)

Behaviour:
- Reset values: ready=1, done=0, result=0x0000, overflow=0, invalid=0, state IDLE, accumulator 0, digit counter 0.
- Reset takes priority over every other event. Reset asserted mid-conversion aborts the conversion:
  - no done pulse;
  - outputs return to their reset values on the next edge.
- States: IDLE, CONV, FINISH.
- IDLE:
  - ready=1.
  - On an edge with start=1: capture negative and all five digits into holding registers, clear the accumulator, set the counter to 4, go to CONV.
- CONV:
  - ready=0.
  - Each edge: acc <= acc*10 + held digit[counter], where acc*10 = (acc<<3)+(acc<<1). The accumulator is 18 bits unsigned, so there is no internal overflow for any digit values.
  - The counter decrements each edge; after the digit0 edge, go to FINISH.
  - Exactly 5 cycles.
- FINISH (one cycle, ready=0): registers the output.
  - invalid = any held digit > 9.
  - Range limit on the magnitude: 32767 if positive, 32768 if negative.
  - If invalid: result=0x0000, overflow=0.
  - Else if the magnitude exceeds the limit: overflow=1. Result is 0x7FFF (positive) or 0x8000 (negative) when SATURATE=1, or the low 16 bits of ±acc when SATURATE=0.
  - Else: overflow=0, result = negative ? -acc : acc.
  - Negative zero yields 0x0000.
  - done=1 for this edge's following cycle only; next state IDLE.
- Latency: start sampled at edge k; result, flags and done valid after edge k+6; ready returns high after edge k+6.
- Back-to-back: start high on the cycle done is high is accepted, giving one conversion per 7 cycles.
- start while ready=0 is ignored and not queued.
- Digit input changes after the capture edge do not affect the conversion in progress.
- result, overflow and invalid hold their values between done pulses.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined: invalid detection exactly as in Behaviour.
- Undefined:
  - invalid output tied to 0;
  - digits 10–15 are accumulated at face value with no special handling;
  - overflow/saturation logic applies normally to the resulting magnitude.

Decomposition:
- Shared package cpu16_pkg holds:
  - state enum {IDLE, CONV, FINISH};
  - NUM_DIGITS=5;
  - ACC_W=18;
  - POS_LIMIT=17'd32767;
  - NEG_LIMIT=17'd32768.
- One sub-module, bcd_mac10: purely combinational, acc_next = acc*10 + digit, 18-bit in/out. The FSM, holding registers and range logic stay in bcd_to_bin16.

Test Plan:
- Positive in range: +12345 (digits 1,2,3,4,5), start pulse → done exactly 6 cycles later, result=0x3039, overflow=0, invalid=0, ready back to 1.
- Negative limits: −32768 → result=0x8000, overflow=0; −00001 → result=0xFFFF; negative with 00000 → result=0x0000.
- Overflow: +40000 with SATURATE=1 → result=0x7FFF, overflow=1; same with SATURATE=0 → result=0x9C40, overflow=1; −32769 with SATURATE=1 → result=0x8000, overflow=1.
- Invalid digit, BCD_DIGIT_CHECK_EN defined: bcd_digit2=0xA, others 0 → invalid=1, result=0x0000, overflow=0. Macro undefined: same input → result=0x03E8 (decimal 1000), invalid=0.
- Handshake:
  - start held high continuously → conversions every 7 cycles;
  - start pulse during CONV → ignored, single done;
  - digits changed during CONV → result reflects the captured values.
- Reset mid-operation: reset asserted 3 cycles into CONV → next cycle ready=1, done=0, result=0x0000, no done pulse; a fresh start then converts normally.
